// File: rtl/prefix_scanner.sv
// Prefix scanner: walks the leading bytes of a captured instruction window, one per cycle,
// and reports the prefix flags and the window shifted past them. PREFIX_SCANNER_SEGMENT_EN enables segment-override decode.
module prefix_scanner #(
   parameter int WINDOW_BYTES = 12,
   parameter int OUT_BYTES    = 10,
   parameter int MAX_PREFIXES = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [8*WINDOW_BYTES-1:0]           in_instr,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [8*OUT_BYTES-1:0]              out_instr,
   output logic                                out_operand_32bit,
   output logic                                out_address_32bit,
   output logic [1:0]                          out_rep,
   output logic                                out_lock,
   output logic [2:0]                          out_segment,
   output logic [$clog2(MAX_PREFIXES+1)-1:0]   out_prefix_count,
   output logic                                out_error
);

   localparam int CW = $clog2(MAX_PREFIXES+1);
   localparam int OW = 8*OUT_BYTES;
   localparam logic [CW-1:0] MAX_K = CW'(MAX_PREFIXES);

   generate
      if (WINDOW_BYTES < OUT_BYTES + MAX_PREFIXES) begin : g_bad_cfg
         $error("prefix_scanner: WINDOW_BYTES must be >= OUT_BYTES + MAX_PREFIXES");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready is high only in IDLE, out_valid only in DONE, so the two never transfer together.
   state_t                    state;
   logic [8*WINDOW_BYTES-1:0] win;
   logic [OW-1:0]             shifted;
   logic [7:0]                cur_byte;
   logic                      is_prefix;
`ifdef PREFIX_SCANNER_SEGMENT_EN
   logic [2:0]                seg_code;
`endif

   // The prefix count doubles as the scan index, so one shift serves both the byte probe and the result.
   always_comb begin
      shifted   = OW'(win >> {out_prefix_count, 3'b000});
      cur_byte  = shifted[7:0];
      is_prefix = 1'b0;
`ifdef PREFIX_SCANNER_SEGMENT_EN
      seg_code  = 3'd0;
`endif
      case (cur_byte)
         8'h66, 8'h67, 8'hF2, 8'hF3, 8'hF0: is_prefix = 1'b1;
`ifdef PREFIX_SCANNER_SEGMENT_EN
         8'h26: begin is_prefix = 1'b1; seg_code = 3'd1; end
         8'h2E: begin is_prefix = 1'b1; seg_code = 3'd2; end
         8'h36: begin is_prefix = 1'b1; seg_code = 3'd3; end
         8'h3E: begin is_prefix = 1'b1; seg_code = 3'd4; end
         8'h64: begin is_prefix = 1'b1; seg_code = 3'd5; end
         8'h65: begin is_prefix = 1'b1; seg_code = 3'd6; end
`endif
         default: ;
      endcase
   end

`ifndef PREFIX_SCANNER_SEGMENT_EN
   assign out_segment = 3'd0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         win               <= '0;
         in_ready          <= 1'b1;
         out_valid         <= 1'b0;
         out_instr         <= '0;
         out_operand_32bit <= 1'b0;
         out_address_32bit <= 1'b0;
         out_rep           <= 2'd0;
         out_lock          <= 1'b0;
`ifdef PREFIX_SCANNER_SEGMENT_EN
         out_segment       <= 3'd0;
`endif
         out_prefix_count  <= '0;
         out_error         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  win               <= in_instr;
                  in_ready          <= 1'b0;
                  out_operand_32bit <= 1'b0;
                  out_address_32bit <= 1'b0;
                  out_rep           <= 2'd0;
                  out_lock          <= 1'b0;
`ifdef PREFIX_SCANNER_SEGMENT_EN
                  out_segment       <= 3'd0;
`endif
                  out_prefix_count  <= '0;
                  out_error         <= 1'b0;
                  state             <= SCAN;
               end
            end
            SCAN: begin
               if (is_prefix && (out_prefix_count != MAX_K)) begin
                  case (cur_byte)
                     8'h66:   out_operand_32bit <= 1'b1;
                     8'h67:   out_address_32bit <= 1'b1;
                     8'hF2:   out_rep           <= 2'd1;
                     8'hF3:   out_rep           <= 2'd2;
                     8'hF0:   out_lock          <= 1'b1;
                     default: ;
                  endcase
`ifdef PREFIX_SCANNER_SEGMENT_EN
                  if (seg_code != 3'd0)
                     out_segment <= seg_code;
`endif
                  out_prefix_count <= out_prefix_count + CW'(1);
               end else begin
                  // A prefix found with the budget spent ends the scan as an error, without touching the flags.
                  out_error <= is_prefix;
                  out_instr <= shifted;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prefix_scanner.sv
// Directed bench for prefix_scanner: drivers push expected results into a queue, a monitor pops and compares.
// Segment expectations follow PREFIX_SCANNER_SEGMENT_EN.
module tb_prefix_scanner;

   localparam int W  = 14;
   localparam int OB = 10;
   localparam int MP = 4;
   localparam int CW = $clog2(MP+1);

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [8*W-1:0]    in_instr;
   logic              out_valid;
   logic              out_ready;
   logic [8*OB-1:0]   out_instr;
   logic              out_operand_32bit;
   logic              out_address_32bit;
   logic [1:0]        out_rep;
   logic              out_lock;
   logic [2:0]        out_segment;
   logic [CW-1:0]     out_prefix_count;
   logic              out_error;

   prefix_scanner #(.WINDOW_BYTES(W), .OUT_BYTES(OB), .MAX_PREFIXES(MP)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_instr          (in_instr),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_instr         (out_instr),
      .out_operand_32bit (out_operand_32bit),
      .out_address_32bit (out_address_32bit),
      .out_rep           (out_rep),
      .out_lock          (out_lock),
      .out_segment       (out_segment),
      .out_prefix_count  (out_prefix_count),
      .out_error         (out_error)
   );

   typedef struct {
      logic [8*OB-1:0] instr;
      logic            op;
      logic            addr;
      logic [1:0]      rep;
      logic            lock;
      logic [2:0]      seg;
      logic [CW-1:0]   cnt;
      logic            err;
      int              due;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   logic have_cur;
   logic chk_ready_next;
   int   cyc;
   int   vectors;
   int   miscompares;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [8*W-1:0] mkwin(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input logic [7:0] b4, input logic [7:0] b5,
                                            input int np);
      logic [7:0] b [6];
      logic [8*W-1:0] r;
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4; b[5] = b5;
      for (int i = 0; i < W; i++)
         r[8*i +: 8] = (i < np) ? b[i] : 8'(8'h10 + i);
      return r;
   endfunction

   function automatic logic [8*OB-1:0] instr_of(input logic [8*W-1:0] w, input int n);
      logic [8*OB-1:0] r;
      for (int i = 0; i < OB; i++)
         r[8*i +: 8] = w[8*(i+n) +: 8];
      return r;
   endfunction

   task automatic run_vec(input logic [8*W-1:0] w, input int n, input logic op, input logic addr,
                          input logic [1:0] rep, input logic lock, input logic [2:0] seg,
                          input logic err, input int hold);
      exp_t e;
      int   t;
      in_instr = w;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("accept_timeout", {127'd0, in_ready}, 128'd1);
      e.instr = instr_of(w, n);
      e.op    = op;
      e.addr  = addr;
      e.rep   = rep;
      e.lock  = lock;
      e.seg   = seg;
      e.cnt   = CW'(n);
      e.err   = err;
      e.due   = cyc + n + 2;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_instr = ~w;
      t = 0;
      while (!out_valid && t < 30) begin
         @(posedge clk); #1;
         t++;
      end
      chk("result_timeout", {127'd0, out_valid}, 128'd1);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (chk_ready_next) begin
            chk("in_ready_after_handshake", {127'd0, in_ready}, 128'd1);
            chk_ready_next = 1'b0;
         end
         if (out_valid) begin
            if (!have_cur) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out_valid", {127'd0, out_valid}, 128'd0);
               end else begin
                  cur = exp_q.pop_front();
                  have_cur = 1'b1;
                  chk("latency_cycle", 128'(cyc), 128'(cur.due));
               end
            end
            if (have_cur) begin
               chk("out_instr",   128'(out_instr), 128'(cur.instr));
               chk("operand",     {127'd0, out_operand_32bit}, {127'd0, cur.op});
               chk("address",     {127'd0, out_address_32bit}, {127'd0, cur.addr});
               chk("rep",         128'(out_rep), 128'(cur.rep));
               chk("lock",        {127'd0, out_lock}, {127'd0, cur.lock});
               chk("segment",     128'(out_segment), 128'(cur.seg));
               chk("count",       128'(out_prefix_count), 128'(cur.cnt));
               chk("error",       {127'd0, out_error}, {127'd0, cur.err});
               chk("in_ready_in_done", {127'd0, in_ready}, 128'd0);
               if (out_ready) begin
                  have_cur = 1'b0;
                  chk_ready_next = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   logic [8*W-1:0] w;
   int             t0;

   initial begin
      cyc = 0; vectors = 0; miscompares = 0;
      have_cur = 1'b0; chk_ready_next = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_fields", {out_instr, out_operand_32bit, out_address_32bit, out_rep, out_lock,
                         out_segment, out_prefix_count, out_error}, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

      // no prefixes
      run_vec(mkwin(8'h0F, 8'h05, 0, 0, 0, 0, 2), 0, 0, 0, 2'd0, 0, 3'd0, 0, 0);
      // rep + operand + address
      run_vec(mkwin(8'hF3, 8'h66, 8'h67, 8'hA5, 0, 0, 4), 3, 1, 1, 2'd2, 0, 3'd0, 0, 1);
      // prefix budget exceeded
      run_vec(mkwin(8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h90, 6), 4, 1, 0, 2'd0, 0, 3'd0, 1, 0);
      // exactly MAX prefixes, then an opcode: no error
      run_vec(mkwin(8'hF0, 8'hF0, 8'hF0, 8'hF0, 0, 0, 4), 4, 0, 0, 2'd0, 1, 3'd0, 0, 2);
      // rep: last occurrence wins
      run_vec(mkwin(8'hF2, 8'hF3, 8'hF2, 8'hC3, 0, 0, 4), 3, 0, 0, 2'd1, 0, 3'd0, 0, 0);
`ifdef PREFIX_SCANNER_SEGMENT_EN
      run_vec(mkwin(8'h64, 8'hF2, 8'hF3, 8'hAE, 0, 0, 4), 3, 0, 0, 2'd2, 0, 3'd5, 0, 0);
      run_vec(mkwin(8'hF0, 8'hF2, 8'h2E, 8'h90, 0, 0, 4), 3, 0, 0, 2'd1, 1, 3'd2, 0, 1);
      run_vec(mkwin(8'h26, 8'h65, 8'h67, 8'h8B, 0, 0, 4), 3, 0, 1, 2'd0, 0, 3'd6, 0, 0);
`else
      run_vec(mkwin(8'h64, 8'hF2, 8'hF3, 8'hAE, 0, 0, 4), 0, 0, 0, 2'd0, 0, 3'd0, 0, 0);
      run_vec(mkwin(8'hF0, 8'hF2, 8'h2E, 8'h90, 0, 0, 4), 2, 0, 0, 2'd1, 1, 3'd0, 0, 1);
      run_vec(mkwin(8'h26, 8'h65, 8'h67, 8'h8B, 0, 0, 4), 0, 0, 0, 2'd0, 0, 3'd0, 0, 0);
`endif
      // back-pressure: outputs held for 5 cycles with out_ready low
      run_vec(mkwin(8'hF3, 8'h66, 8'h67, 8'hA5, 0, 0, 4), 3, 1, 1, 2'd2, 0, 3'd0, 0, 5);

      // reset in the middle of a scan discards the window
      w = mkwin(8'hF3, 8'hF3, 8'h90, 0, 0, 0, 3);
      in_instr = w;
      in_valid = 1'b1;
      t0 = 0;
      while (!in_ready && t0 < 50) begin
         @(posedge clk); #1;
         t0++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
      chk("abort_rep", 128'(out_rep), 128'd0);
      chk("abort_count", 128'(out_prefix_count), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_result", {127'd0, out_valid}, 128'd0);
      chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
      run_vec(w, 2, 0, 0, 2'd2, 0, 3'd0, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prefix_scanner.md
PREFIX_SCANNER -- requirements
Module: prefix_scanner

Interface
REQ-001 Parameter WINDOW_BYTES, default 12, raw instruction window width in bytes.
REQ-002 Parameter OUT_BYTES, default 10, unprefixed instruction width in bytes.
REQ-003 Parameter MAX_PREFIXES, default 4, maximum prefix bytes consumed; WINDOW_BYTES >= OUT_BYTES+MAX_PREFIXES SHALL hold, else elaboration fails.
REQ-004 Port list, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  raw window valid.
- in_ready  out  1  block accepts window.
- in_instr  in  8*WINDOW_BYTES  raw bytes, byte 0 in bits [7:0].
- out_valid  out  1  decode result valid.
- out_ready  in  1  consumer accepts result.
- out_instr  out  8*OUT_BYTES  window shifted past prefixes.
- out_operand_32bit  out  1  0x66 seen.
- out_address_32bit  out  1  0x67 seen.
- out_rep  out  2  0 none, 1 REPNE (F2), 2 REP (F3).
- out_lock  out  1  0xF0 seen.
- out_segment  out  3  segment override code.
- out_prefix_count  out  $clog2(MAX_PREFIXES+1)  prefixes consumed.
- out_error  out  1  prefix limit exceeded.

Function
REQ-005 States IDLE, SCAN, DONE; IDLE->SCAN on in_valid&&in_ready; SCAN->DONE on terminating byte; DONE->IDLE on out_valid&&out_ready.
REQ-006 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-007 On accept, window SHALL be captured into an internal register; later in_instr changes SHALL not affect the result.
REQ-008 SCAN SHALL examine one byte per cycle, byte index k starting at 0, in any prefix order.
REQ-009 Prefix bytes: 66, 67, F2, F3, F0, plus segment bytes when REQ-020 applies; any other byte terminates scan.
REQ-010 A prefix byte at k<MAX_PREFIXES SHALL update flags and increment k; duplicates allowed; for rep and segment the last occurrence wins.
REQ-011 A prefix byte at k==MAX_PREFIXES SHALL terminate scan with out_error=1; no flag update for that byte.
REQ-012 Latency: accept at cycle T with N prefixes -> out_valid at T+N+2.
REQ-013 out_instr SHALL equal window bytes [N .. N+OUT_BYTES-1], N=out_prefix_count.
REQ-014 Outputs SHALL hold stable throughout DONE while out_ready=0.
REQ-015 After DONE->IDLE, in_ready SHALL rise the following cycle; no same-cycle output handshake and input accept.
REQ-016 Flags and count SHALL clear on each accept.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, all output fields 0.
REQ-018 Reset during SCAN or DONE SHALL discard the in-flight window; no out_valid for it.

Configuration
REQ-019 Macro PREFIX_SCANNER_SEGMENT_EN selects segment-override decode.
REQ-020 Defined: 26->1 ES, 2E->2 CS, 36->3 SS, 3E->4 DS, 64->5 FS, 65->6 GS, none->0; these count as prefixes.
REQ-021 Undefined: segment bytes terminate scan as opcode bytes; out_segment tied 0.

Verification
REQ-022 Window 0F 05 ... -> out_valid at T+2, count 0, all flags 0, out_instr low byte 0F.
REQ-023 Window F3 66 67 A5 ... -> T+5, rep=2, operand=1, address=1, count 3, out_instr low byte A5.
REQ-024 Window 66 66 66 66 66 90 (MAX_PREFIXES=4) -> count 4, out_error=1, operand=1, out_instr low byte 66.
REQ-025 Window 64 F2 F3 AE: with macro -> segment 5, rep 2, count 3; without -> count 0, out_instr low byte 64.
REQ-026 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-027 Assert rst_n=0 mid-SCAN of F3 F3 90 -> out_valid never rises for it; next window decodes correctly.
